// File: rtl/tlb_update_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------------------------+
// | tlb_update_arbiter: arbitrates init, software and page-walk fill writes into the TLB RAM  |
// | Rev 1.0                                                                                   |
// +------------------------------------------------------------------------------------------+
module tlb_update_arbiter #(
   parameter int  TLB_ENTRIES = 512,
   parameter int  ASSOC       = 4,
   parameter int  WID         = $clog2(TLB_ENTRIES),
   parameter int  AW          = $clog2(ASSOC),
   parameter type tlb_entry_t = logic [63:0]
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WID:0]     i_init_cnt,
   input  logic [WID-1:0]   i_init_entry_no,
   input  tlb_entry_t       i_init_entry,
   input  logic             i_sw_req,
   output logic             o_sw_ack,
   input  logic [AW-1:0]    i_sw_way,
   input  logic [WID-1:0]   i_sw_entry_no,
   input  tlb_entry_t       i_sw_entry,
   input  logic             i_fill_req,
   output logic             o_fill_ack,
   input  logic [WID-1:0]   i_fill_entry_no,
   input  tlb_entry_t       i_fill_entry,
   output logic             o_fill_err,
   output logic             o_rd_en,
   output logic [WID-1:0]   o_rd_addr,
   input  logic [ASSOC-1:0] i_rd_lock,
   output logic             o_wr_en,
   output logic [ASSOC-1:0] o_wr_way,
   output logic [WID-1:0]   o_wr_addr,
   output tlb_entry_t       o_wr_data,
   output logic             o_init_done
);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_IDLE    = 3'd1,
      S_SW_WR   = 3'd2,
      S_FILL_RD = 3'd3,
      S_FILL_WR = 3'd4
   } state_t;

   localparam logic [15:0] c_LFSR_SEED = 16'hACE1;
   localparam logic [15:0] c_LFSR_MASK = 16'hB400;

   state_t          r_state;
   state_t          w_next;
   logic [AW-1:0]   r_way;
   logic [WID-1:0]  r_addr;
   tlb_entry_t      r_data;
   logic [15:0]     r_lfsr;
   logic            w_vic_found;
   logic [AW-1:0]   w_vic;
   logic            w_unused;

   // Only the completion bit of the init counter matters here.
   assign w_unused = ^i_init_cnt[WID-1:0];

   // Highest offset is visited first so the lowest offset from the start way wins.
   always_comb begin
      logic [AW-1:0] v_idx;
      w_vic_found = 1'b0;
      w_vic       = '0;
      v_idx       = '0;
      for (int i = ASSOC - 1; i >= 0; i--) begin
         v_idx = r_lfsr[AW-1:0] + AW'(i);
         if (!i_rd_lock[v_idx]) begin
            w_vic_found = 1'b1;
            w_vic       = v_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_INIT;
         r_way   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_lfsr  <= c_LFSR_SEED;
      end else begin
         r_state <= w_next;
         r_lfsr  <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? c_LFSR_MASK : 16'h0000);
         if (r_state == S_IDLE) begin
            if (i_sw_req) begin
               r_way  <= i_sw_way;
               r_addr <= i_sw_entry_no;
               r_data <= i_sw_entry;
            end else if (i_fill_req) begin
               r_addr <= i_fill_entry_no;
               r_data <= i_fill_entry;
            end
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      o_sw_ack   = 1'b0;
      o_fill_ack = 1'b0;
      o_fill_err = 1'b0;
      o_rd_en    = 1'b0;
      o_rd_addr  = r_addr;
      o_wr_en    = 1'b0;
      o_wr_way   = '0;
      o_wr_addr  = r_addr;
      o_wr_data  = r_data;
      case (r_state)
         S_INIT: begin
            if (i_init_cnt[WID]) begin
               w_next = S_IDLE;
            end else begin
               o_wr_en   = 1'b1;
               o_wr_way  = {1'b1, {(ASSOC-1){1'b0}}};
               o_wr_addr = i_init_entry_no;
               o_wr_data = i_init_entry;
            end
         end
         S_IDLE: begin
            if (i_sw_req)        w_next = S_SW_WR;
            else if (i_fill_req) w_next = S_FILL_RD;
         end
         S_SW_WR: begin
            o_wr_en  = 1'b1;
            o_wr_way = ASSOC'(1) << r_way;
            o_sw_ack = 1'b1;
            w_next   = S_IDLE;
         end
         S_FILL_RD: begin
            o_rd_en = 1'b1;
            w_next  = S_FILL_WR;
         end
         S_FILL_WR: begin
            o_fill_ack = 1'b1;
            if (w_vic_found) begin
               o_wr_en  = 1'b1;
               o_wr_way = ASSOC'(1) << w_vic;
            end else begin
               o_fill_err = 1'b1;
            end
            w_next = S_IDLE;
         end
         default: w_next = S_INIT;
      endcase
      // A reset cycle aborts whatever the current state would have issued.
      if (rst) begin
         o_sw_ack   = 1'b0;
         o_fill_ack = 1'b0;
         o_fill_err = 1'b0;
         o_rd_en    = 1'b0;
         o_wr_en    = 1'b0;
         o_wr_way   = '0;
      end
   end

   assign o_init_done = (r_state != S_INIT) && !rst;

endmodule
`default_nettype wire

// File: tb/tb_tlb_update_arbiter.sv
`default_nettype none
// tb_tlb_update_arbiter: directed stimulus with a cycle-tagged expected-event scoreboard.
module tb_tlb_update_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [9:0]  init_cnt;
   logic [8:0]  init_entry_no;
   logic [63:0] init_entry;
   logic        sw_req, sw_ack;
   logic [1:0]  sw_way;
   logic [8:0]  sw_entry_no;
   logic [63:0] sw_entry;
   logic        fill_req, fill_ack, fill_err;
   logic [8:0]  fill_entry_no;
   logic [63:0] fill_entry;
   logic        rd_en;
   logic [8:0]  rd_addr;
   logic [3:0]  rd_lock;
   logic        wr_en;
   logic [3:0]  wr_way;
   logic [8:0]  wr_addr;
   logic [63:0] wr_data;
   logic        init_done;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [15:0] tb_lfsr;

   typedef struct {
      int          cyc;
      logic        rd;
      logic [8:0]  ra;
      logic        we;
      logic [3:0]  way;
      logic [8:0]  wa;
      logic [63:0] wd;
      logic        sa;
      logic        fa;
      logic        fe;
   } ev_t;
   ev_t sb[$];
   ev_t m_e;

   tlb_update_arbiter dut (
      .clk(clk), .rst(rst),
      .i_init_cnt(init_cnt), .i_init_entry_no(init_entry_no), .i_init_entry(init_entry),
      .i_sw_req(sw_req), .o_sw_ack(sw_ack), .i_sw_way(sw_way),
      .i_sw_entry_no(sw_entry_no), .i_sw_entry(sw_entry),
      .i_fill_req(fill_req), .o_fill_ack(fill_ack),
      .i_fill_entry_no(fill_entry_no), .i_fill_entry(fill_entry), .o_fill_err(fill_err),
      .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_lock(rd_lock),
      .o_wr_en(wr_en), .o_wr_way(wr_way), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
      .o_init_done(init_done)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] lfsr_adv(input logic [15:0] v, input int n);
      logic [15:0] r;
      r = v;
      for (int i = 0; i < n; i++) r = {1'b0, r[15:1]} ^ (r[0] ? 16'hB400 : 16'h0000);
      return r;
   endfunction

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      tb_lfsr <= rst ? 16'hACE1 : lfsr_adv(tb_lfsr, 1);
   end

   task automatic push_ev(input int c, input logic rd, input logic [8:0] ra, input logic we,
                          input logic [3:0] way, input logic [8:0] wa, input logic [63:0] wd,
                          input logic sa, input logic fa, input logic fe);
      ev_t e;
      e.cyc = c; e.rd = rd; e.ra = ra; e.we = we; e.way = way;
      e.wa = wa; e.wd = wd; e.sa = sa; e.fa = fa; e.fe = fe;
      sb.push_back(e);
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every strobe must match the queued event tagged for this very cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++;
         errors++;
         $display("FAIL missed_event: expected at cycle %0d, not seen by cycle %0d", sb[0].cyc, cyc);
         void'(sb.pop_front());
      end
      if (rd_en || wr_en || sw_ack || fill_ack || fill_err) begin
         checks++;
         if (sb.size() == 0 || sb[0].cyc != cyc) begin
            errors++;
            $display("FAIL unexpected_event: cycle %0d rd_en=%b wr_en=%b way=%b addr=%0d sw_ack=%b fill_ack=%b fill_err=%b, required none",
                     cyc, rd_en, wr_en, wr_way, wr_addr, sw_ack, fill_ack, fill_err);
         end else begin
            m_e = sb.pop_front();
            if (rd_en !== m_e.rd || (m_e.rd && rd_addr !== m_e.ra) || wr_en !== m_e.we ||
                wr_way !== m_e.way || (m_e.we && (wr_addr !== m_e.wa || wr_data !== m_e.wd)) ||
                sw_ack !== m_e.sa || fill_ack !== m_e.fa || fill_err !== m_e.fe) begin
               errors++;
               $display("FAIL event_cycle_%0d: got rd=%b ra=%0d we=%b way=%b wa=%0d wd=%h sa=%b fa=%b fe=%b; expected rd=%b ra=%0d we=%b way=%b wa=%0d wd=%h sa=%b fa=%b fe=%b",
                        cyc, rd_en, rd_addr, wr_en, wr_way, wr_addr, wr_data, sw_ack, fill_ack, fill_err,
                        m_e.rd, m_e.ra, m_e.we, m_e.way, m_e.wa, m_e.wd, m_e.sa, m_e.fa, m_e.fe);
            end
         end
      end
   end

   // Starts at posedge+1 of some cycle; returns in the first cycle with init_done high.
   task automatic reset_and_init();
      int r;
      rst      = 1'b1;
      init_cnt = '0;
      repeat (3) begin
         @(posedge clk); #1;
         chk("init_done_in_reset", init_done, 0);
      end
      rst = 1'b0;
      r   = cyc;
      for (int i = 0; i < 64; i++) begin
         init_cnt      = 10'(448 + i);
         init_entry_no = 9'(448 + i);
         init_entry    = 64'hC0DE_0000_0000_0000 | 64'(i * 3);
         push_ev(r + i, 0, 0, 1, 4'b1000, 9'(448 + i), 64'hC0DE_0000_0000_0000 | 64'(i * 3), 0, 0, 0);
         @(posedge clk); #1;
      end
      init_cnt = 10'd512;
      chk("init_done_at_cnt512", init_done, 0);
      @(posedge clk); #1;
      chk("init_done_after_init", init_done, 1);
   endtask

   task automatic sw_write(input logic [1:0] way, input logic [8:0] addr, input logic [63:0] data,
                           input logic [3:0] exp_way, input int hold);
      sw_req = 1'b1; sw_way = way; sw_entry_no = addr; sw_entry = data;
      push_ev(cyc + 1, 0, 0, 1, exp_way, addr, data, 1, 0, 0);
      if (hold == 4) push_ev(cyc + 3, 0, 0, 1, exp_way, addr, data, 1, 0, 0);
      repeat (hold) @(posedge clk);
      #1 sw_req = 1'b0;
      @(posedge clk); #1;
   endtask

   // start < 0: any LFSR start way; otherwise idle until the FILL_WR cycle sees that start way.
   task automatic fill(input logic [8:0] addr, input logic [63:0] data, input logic [3:0] lock,
                       input int start, input logic [3:0] exp_way);
      logic [15:0] p;
      int n;
      rd_lock = lock;
      if (start >= 0) begin
         n = 0;
         p = lfsr_adv(tb_lfsr, 2);
         while (int'(p[1:0]) != start && n < 100) begin
            @(posedge clk); #1;
            p = lfsr_adv(tb_lfsr, 2);
            n++;
         end
         chk("lfsr_start_reached", 64'(p[1:0]), 64'(start));
      end
      fill_req = 1'b1; fill_entry_no = addr; fill_entry = data;
      push_ev(cyc + 1, 1, addr, 0, 4'b0000, 0, 0, 0, 0, 0);
      push_ev(cyc + 2, 0, 0, exp_way != 0, exp_way, addr, data, 0, 1, exp_way == 0);
      repeat (3) @(posedge clk);
      #1 fill_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; init_cnt = '0; init_entry_no = '0; init_entry = '0;
      sw_req = 0; sw_way = 0; sw_entry_no = 0; sw_entry = 0;
      fill_req = 0; fill_entry_no = 0; fill_entry = 0; rd_lock = 4'b0000;
      @(posedge clk); #1;

      reset_and_init();

      sw_write(2'd2, 9'd5,   64'h1111_2222_3333_4444, 4'b0100, 2);
      sw_write(2'd0, 9'd0,   64'hFFFF_0000_FFFF_0000, 4'b0001, 2);
      sw_write(2'd3, 9'd511, 64'h0123_4567_89AB_CDEF, 4'b1000, 2);
      // Request held past the ack is served again as a new request.
      sw_write(2'd1, 9'd77,  64'hDEAD_BEEF_0000_0077, 4'b0010, 4);

      // Simultaneous requests: software first, fill afterwards.
      rd_lock = 4'b0111;
      sw_req = 1; sw_way = 2'd1; sw_entry_no = 9'd10; sw_entry = 64'hAAAA;
      fill_req = 1; fill_entry_no = 9'd20; fill_entry = 64'hBBBB;
      push_ev(cyc + 1, 0, 0, 1, 4'b0010, 9'd10, 64'hAAAA, 1, 0, 0);
      push_ev(cyc + 3, 1, 9'd20, 0, 4'b0000, 0, 0, 0, 0, 0);
      push_ev(cyc + 4, 0, 0, 1, 4'b1000, 9'd20, 64'hBBBB, 0, 1, 0);
      repeat (2) @(posedge clk);
      #1 sw_req = 0;
      repeat (3) @(posedge clk);
      #1 fill_req = 0;
      @(posedge clk); #1;

      fill(9'd100, 64'h5555_0000_0000_0001, 4'b1011, 0, 4'b0100);
      fill(9'd101, 64'h5555_0000_0000_0002, 4'b1011, 3, 4'b0100);
      fill(9'd102, 64'h5555_0000_0000_0003, 4'b0110, 0, 4'b0001);
      fill(9'd103, 64'h5555_0000_0000_0004, 4'b0110, 1, 4'b1000);
      fill(9'd104, 64'h5555_0000_0000_0005, 4'b1111, -1, 4'b0000);

      // Reset during FILL_RD: nothing issued, INIT reruns, then the still-held fill is served.
      rd_lock = 4'b1101;
      fill_req = 1; fill_entry_no = 9'd33; fill_entry = 64'h7777_0000_0000_0033;
      @(posedge clk); #1;
      reset_and_init();
      push_ev(cyc + 1, 1, 9'd33, 0, 4'b0000, 0, 0, 0, 0, 0);
      push_ev(cyc + 2, 0, 0, 1, 4'b0010, 9'd33, 64'h7777_0000_0000_0033, 0, 1, 0);
      repeat (3) @(posedge clk);
      #1 fill_req = 0;

      repeat (5) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(sb.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
